// File: rtl/apu_note_sequencer_if.sv
// Note-write handshake from the register logic and the channel control bundle.
// The slave modport is the sequencer's view; master is the CPU/channel side.
interface apu_note_sequencer_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_period;
    logic [15:0] wr_duty;
    logic [15:0] wr_volume;
    logic [15:0] wr_length;
    logic [15:0] wr_decay;
    logic [15:0] ch_period;
    logic [15:0] ch_duty;
    logic [15:0] ch_volume;
    logic        ch_rstn;

    modport slave (
        input  wr_valid, wr_period, wr_duty, wr_volume, wr_length, wr_decay,
        output wr_ready, ch_period, ch_duty, ch_volume, ch_rstn
    );

    modport master (
        output wr_valid, wr_period, wr_duty, wr_volume, wr_length, wr_decay,
        input  wr_ready, ch_period, ch_duty, ch_volume, ch_rstn
    );
endinterface

// File: rtl/apu_note_sequencer.sv
// Queues square-channel notes and plays them back-to-back with a linear decay envelope.
// Latency: write->LOAD 1 cycle, new ch_* after 2; backpressure: wr_ready low while the queue is full.
module apu_note_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 tick,
    apu_note_sequencer_if.slave  bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     fifo_count,
    output logic                 underrun
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [15:0] period;
        logic [15:0] duty;
        logic [15:0] volume;
        logic [15:0] length;
        logic [15:0] decay;
    } note_t;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

    note_t         mem [DEPTH];
    note_t         wr_note;
    note_t         head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    state_t        state;
    logic [15:0]   remaining;
    logic [15:0]   decay_q;
    logic [16:0]   vol_diff;
    logic [15:0]   vol_next;

    assign wr_note = '{period: bus.wr_period, duty: bus.wr_duty, volume: bus.wr_volume,
                       length: bus.wr_length, decay: bus.wr_decay};

    assign bus.wr_ready = (fifo_count != CNT_W'(DEPTH));
    assign push         = bus.wr_valid && bus.wr_ready;
    assign pop          = (state == LOAD);
    assign head         = mem[rd_ptr];

    // Borrow out of the 17-bit difference means the envelope has bottomed out.
    assign vol_diff = {1'b0, bus.ch_volume} - {1'b0, decay_q};
    assign vol_next = vol_diff[16] ? 16'd0 : vol_diff[15:0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_note;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            remaining     <= '0;
            decay_q       <= '0;
            bus.ch_period <= '0;
            bus.ch_duty   <= '0;
            bus.ch_volume <= '0;
            bus.ch_rstn   <= 1'b0;
            busy          <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            underrun <= 1'b0;
            case (state)
                IDLE: begin
                    bus.ch_volume <= '0;
                    if (enable && fifo_count != '0) begin
                        state       <= LOAD;
                        bus.ch_rstn <= 1'b0;
                        busy        <= 1'b1;
                    end else begin
                        bus.ch_rstn <= 1'b1;
                        busy        <= 1'b0;
                    end
                end

                LOAD: begin
                    remaining <= head.length;
                    decay_q   <= head.decay;
                    if (head.length != '0) begin
                        state         <= PLAY;
                        bus.ch_period <= head.period;
                        bus.ch_duty   <= head.duty;
                        bus.ch_volume <= head.volume;
                        bus.ch_rstn   <= 1'b1;
                        busy          <= 1'b1;
                    end else if (enable && fifo_count > CNT_W'(1)) begin
                        // Zero-length entry is dropped; chain straight into the next one.
                        state       <= LOAD;
                        bus.ch_rstn <= 1'b0;
                        busy        <= 1'b1;
                    end else begin
                        state         <= IDLE;
                        bus.ch_volume <= '0;
                        bus.ch_rstn   <= 1'b1;
                        busy          <= 1'b0;
                    end
                end

                PLAY: begin
                    if (!enable) begin
                        state         <= IDLE;
                        bus.ch_volume <= '0;
                        bus.ch_rstn   <= 1'b1;
                        busy          <= 1'b0;
                    end else if (tick) begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            if (fifo_count != '0) begin
                                state         <= LOAD;
                                bus.ch_volume <= vol_next;
                                bus.ch_rstn   <= 1'b0;
                                busy          <= 1'b1;
                            end else begin
                                state         <= IDLE;
                                bus.ch_volume <= '0;
                                bus.ch_rstn   <= 1'b1;
                                busy          <= 1'b0;
                                underrun      <= 1'b1;
                            end
                        end else begin
                            bus.ch_volume <= vol_next;
                        end
                    end
                end

                default: begin
                    state       <= IDLE;
                    bus.ch_rstn <= 1'b1;
                    busy        <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apu_note_sequencer.sv
// Bench for apu_note_sequencer: directed scenarios plus random note batches
// checked against a queue-of-notes model with closed-form envelope values.
module tb_apu_note_sequencer;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    typedef struct {
        int period;
        int duty;
        int volume;
        int length;
        int decay;
    } note_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic             tick = 1'b0;
    logic             busy;
    logic             underrun;
    logic [CNT_W-1:0] fifo_count;

    int    checks = 0;
    int    errors = 0;
    note_t mq[$];

    apu_note_sequencer_if bus();

    apu_note_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .tick       (tick),
        .bus        (bus),
        .busy       (busy),
        .fifo_count (fifo_count),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_vol(input note_t n, input int k);
        longint r;
        r = longint'(n.volume) - longint'(k) * longint'(n.decay);
        return (r < 0) ? 0 : int'(r);
    endfunction

    task automatic drive_wr(input int p, input int d, input int v, input int l, input int dc);
        bus.wr_valid  = 1'b1;
        bus.wr_period = 16'(p);
        bus.wr_duty   = 16'(d);
        bus.wr_volume = 16'(v);
        bus.wr_length = 16'(l);
        bus.wr_decay  = 16'(dc);
    endtask

    // Writes only while playback is stopped, so the model's queue size is the occupancy.
    task automatic write_note(input int p, input int d, input int v, input int l, input int dc);
        note_t n;
        n = '{p, d, v, l, dc};
        drive_wr(p, d, v, l, dc);
        if (mq.size() < DEPTH) mq.push_back(n);
        step();
        bus.wr_valid = 1'b0;
    endtask

    task automatic wait_rstn(input logic val, input string tag);
        for (int i = 0; i < 64 && bus.ch_rstn !== val; i++) step();
        chk(tag, 32'(bus.ch_rstn), 32'(val));
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    // Drains the model queue, checking every LOAD run, note start and tick.
    task automatic play_queue();
        note_t n;
        int    skips;
        int    nload;
        int    gap;
        while (mq.size() > 0) begin
            skips = 0;
            nload = 0;
            wait_rstn(1'b0, "enter_load");
            while (bus.ch_rstn === 1'b0 && nload < 16) begin
                nload++;
                step();
            end
            while (mq.size() > 0 && mq[0].length == 0) begin
                void'(mq.pop_front());
                skips++;
            end
            if (mq.size() == 0) begin
                chk("skip_only_loads", 32'(nload), 32'(skips));
                chk("skip_only_busy", 32'(busy), 32'(0));
                chk("skip_only_underrun", 32'(underrun), 32'(0));
                chk("skip_only_vol", 32'(bus.ch_volume), 32'(0));
            end else begin
                n = mq.pop_front();
                chk("load_cycles", 32'(nload), 32'(skips + 1));
                chk("start_period", 32'(bus.ch_period), 32'(n.period));
                chk("start_duty", 32'(bus.ch_duty), 32'(n.duty));
                chk("start_volume", 32'(bus.ch_volume), 32'(n.volume));
                for (int k = 1; k <= n.length; k++) begin
                    gap = $urandom_range(0, 2);
                    for (int g = 0; g < gap; g++) begin
                        step();
                        chk("hold_volume", 32'(bus.ch_volume), 32'(exp_vol(n, k - 1)));
                    end
                    pulse_tick();
                    if (k < n.length) begin
                        chk("tick_volume", 32'(bus.ch_volume), 32'(exp_vol(n, k)));
                        chk("tick_busy", 32'(busy), 32'(1));
                    end else if (mq.size() > 0) begin
                        chk("end_volume_next", 32'(bus.ch_volume), 32'(exp_vol(n, k)));
                        chk("end_rstn_next", 32'(bus.ch_rstn), 32'(0));
                        chk("end_no_underrun", 32'(underrun), 32'(0));
                    end else begin
                        chk("end_volume_idle", 32'(bus.ch_volume), 32'(0));
                        chk("end_underrun", 32'(underrun), 32'(1));
                        chk("end_busy", 32'(busy), 32'(0));
                        step();
                        chk("underrun_pulse", 32'(underrun), 32'(0));
                    end
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_valid  = 1'b0;
        bus.wr_period = '0;
        bus.wr_duty   = '0;
        bus.wr_volume = '0;
        bus.wr_length = '0;
        bus.wr_decay  = '0;

        // Reset state
        step();
        step();
        chk("rst_count", 32'(fifo_count), 32'(0));
        chk("rst_period", 32'(bus.ch_period), 32'(0));
        chk("rst_duty", 32'(bus.ch_duty), 32'(0));
        chk("rst_volume", 32'(bus.ch_volume), 32'(0));
        chk("rst_rstn", 32'(bus.ch_rstn), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_underrun", 32'(underrun), 32'(0));
        chk("rst_ready", 32'(bus.wr_ready), 32'(1));
        rst = 1'b0;
        step();
        chk("idle_rstn", 32'(bus.ch_rstn), 32'(1));

        // Single note with exact latency: write at edge N into empty queue
        enable = 1'b1;
        drive_wr(100, 50, 'h4000, 3, 0);
        step();
        bus.wr_valid = 1'b0;
        chk("lat_count_n", 32'(fifo_count), 32'(1));
        chk("lat_busy_n", 32'(busy), 32'(0));
        step();
        chk("lat_load_rstn", 32'(bus.ch_rstn), 32'(0));
        chk("lat_load_busy", 32'(busy), 32'(1));
        chk("lat_load_vol", 32'(bus.ch_volume), 32'(0));
        step();
        chk("lat_play_rstn", 32'(bus.ch_rstn), 32'(1));
        chk("lat_play_period", 32'(bus.ch_period), 32'(100));
        chk("lat_play_duty", 32'(bus.ch_duty), 32'(50));
        chk("lat_play_vol", 32'(bus.ch_volume), 32'('h4000));
        chk("lat_play_count", 32'(fifo_count), 32'(0));
        tick = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("single_tick_vol", 32'(bus.ch_volume), 32'('h4000));
            chk("single_tick_busy", 32'(busy), 32'(1));
        end
        step();
        tick = 1'b0;
        chk("single_end_vol", 32'(bus.ch_volume), 32'(0));
        chk("single_end_underrun", 32'(underrun), 32'(1));
        chk("single_end_busy", 32'(busy), 32'(0));
        step();
        chk("single_underrun_clear", 32'(underrun), 32'(0));
        chk("single_period_hold", 32'(bus.ch_period), 32'(100));
        enable = 1'b0;

        // Decay envelope saturating at zero
        write_note(300, 150, 'h1000, 4, 'h0600);
        enable = 1'b1;
        play_queue();
        enable = 1'b0;

        // Fill to DEPTH with playback disabled; the fifth write bounces
        for (int i = 0; i < 5; i++) begin
            chk("fill_ready", 32'(bus.wr_ready), 32'(mq.size() < DEPTH));
            write_note(40 + i, 20 + i, 'h0100 * (i + 1), 1, 'h0010);
            chk("fill_count", 32'(fifo_count), 32'(mq.size()));
            chk("fill_busy", 32'(busy), 32'(0));
        end
        chk("fill_final_count", 32'(fifo_count), 32'(DEPTH));
        enable = 1'b1;
        play_queue();
        enable = 1'b0;

        // Back-to-back notes
        write_note(10, 5, 'h3000, 2, 'h0100);
        write_note(20, 10, 'h2000, 2, 'h0200);
        write_note(30, 15, 'h1000, 2, 'h0300);
        enable = 1'b1;
        play_queue();
        enable = 1'b0;

        // Zero-length entry discarded without underrun
        write_note(99, 9, 'h0500, 0, 0);
        write_note(7, 3, 'h0700, 2, 0);
        enable = 1'b1;
        play_queue();
        enable = 1'b0;

        // enable dropped mid-note, then resumed
        write_note(11, 4, 'h2000, 4, 'h0100);
        write_note(12, 5, 'h2100, 2, 'h0100);
        write_note(13, 6, 'h2200, 1, 'h0100);
        enable = 1'b1;
        wait_rstn(1'b0, "drop_load");
        wait_rstn(1'b1, "drop_play");
        void'(mq.pop_front());
        pulse_tick();
        chk("drop_vol_tick", 32'(bus.ch_volume), 32'('h1F00));
        enable = 1'b0;
        step();
        chk("drop_busy", 32'(busy), 32'(0));
        chk("drop_vol", 32'(bus.ch_volume), 32'(0));
        chk("drop_count", 32'(fifo_count), 32'(mq.size()));
        chk("drop_underrun", 32'(underrun), 32'(0));
        step();
        step();
        chk("drop_count_hold", 32'(fifo_count), 32'(2));
        enable = 1'b1;
        play_queue();
        enable = 1'b0;

        // Asynchronous reset mid-note loses everything
        write_note(55, 22, 'h1234, 4, 0);
        write_note(66, 33, 'h2345, 4, 0);
        enable = 1'b1;
        wait_rstn(1'b0, "arst_load");
        wait_rstn(1'b1, "arst_play");
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(fifo_count), 32'(0));
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_vol", 32'(bus.ch_volume), 32'(0));
        chk("arst_period", 32'(bus.ch_period), 32'(0));
        chk("arst_rstn", 32'(bus.ch_rstn), 32'(0));
        mq.delete();
        enable = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("arst_release_rstn", 32'(bus.ch_rstn), 32'(1));
        chk("arst_release_busy", 32'(busy), 32'(0));

        // Random batches
        for (int it = 0; it < 12; it++) begin
            int nwr;
            int len;
            int dc;
            nwr = $urandom_range(1, DEPTH);
            for (int w = 0; w < nwr; w++) begin
                len = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 4);
                case ($urandom_range(0, 2))
                    0:       dc = 0;
                    1:       dc = $urandom_range(1, 'h0400);
                    default: dc = $urandom_range(0, 'hFFFF);
                endcase
                write_note($urandom_range(0, 'hFFFF), $urandom_range(0, 'hFFFF),
                           $urandom_range(0, 'h7FFF), len, dc);
            end
            chk("rand_count", 32'(fifo_count), 32'(mq.size()));
            enable = 1'b1;
            play_queue();
            step();
            chk("rand_drained", 32'(fifo_count), 32'(0));
            chk("rand_idle", 32'(busy), 32'(0));
            enable = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
